gpu_ring_stop: RTL and testbench



---
 rtl/gpu_ring_stop.sv | 142 ++++++++++++++
 tb/tb_gpu_ring_stop.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_ring_stop.sv
// gpu_ring_stop: one node's stop on the unidirectional inter-GPU ring.
// Ring flits addressed to NODE_ID are ejected to the local GPU, all others are
// forwarded downstream. GPU flits enter the ring through a small injection
// FIFO, and a starvation guard forces an injection slot after STARVE_MAX
// consecutive pass-through wins.
module gpu_ring_stop #(
  parameter int NODE_ID    = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  input  logic [15:0]                     loc_tx_data,
  input  logic                            loc_tx_valid,
  output logic                            loc_tx_ready,
  output logic [15:0]                     loc_rx_data,
  output logic                            loc_rx_valid,
  input  logic                            loc_rx_ready,
  input  logic [15:0]                     ring_in_data,
  input  logic                            ring_in_valid,
  output logic                            ring_in_ready,
  output logic [15:0]                     ring_out_data,
  output logic                            ring_out_valid,
  input  logic                            ring_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [15:0]                     inj_cnt,
  output logic [15:0]                     fwd_cnt,
  output logic [15:0]                     ej_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [SW-1:0] starve_cnt;

  logic is_local;
  logic out_free;
  logic ej_free;
  logic fifo_nonempty;
  logic force_inj;
  logic push;
  logic inj_grant;
  logic fwd_acc;
  logic ej_acc;

  // Handshake decisions, all derived from registered state plus the ring input.
  always_comb begin
    is_local      = (ring_in_data[15:10] == 6'(NODE_ID));
    out_free      = !ring_out_valid || ring_out_ready;
    ej_free       = !loc_rx_valid || loc_rx_ready;
    fifo_nonempty = (fifo_level != '0);
    force_inj     = (starve_cnt == SW'(STARVE_MAX)) && fifo_nonempty;
    loc_tx_ready  = (fifo_level != LW'(FIFO_DEPTH));
    // Head-of-line ring input: a stalled local flit blocks everything behind it.
    ring_in_ready = is_local ? ej_free : (out_free && !force_inj);
    push          = loc_tx_valid && loc_tx_ready;
    ej_acc        = ring_in_valid && is_local && ej_free;
    fwd_acc       = ring_in_valid && !is_local && out_free && !force_inj;
    inj_grant     = out_free && fifo_nonempty &&
                    (force_inj || !(ring_in_valid && !is_local));
  end

  // Injection FIFO storage; pointers wrap naturally because the depth is a power of 2.
  // NOTE: the storage array has no reset; validity is tracked by fifo_level alone,
  // which keeps the array mappable to plain RAM/flops without reset fan-out.
  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr] <= loc_tx_data;
  end

  // FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block above.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + 1'b1;
      if (inj_grant) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(inj_grant);
    end
  end

  // Output register: injection and forwarding are mutually exclusive winners.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ring_out_valid <= 1'b0;
      ring_out_data  <= '0;
    end else if (inj_grant) begin
      ring_out_valid <= 1'b1;
      ring_out_data  <= fifo_mem[rd_ptr];
    end else if (fwd_acc) begin
      ring_out_valid <= 1'b1;
      ring_out_data  <= ring_in_data;
    end else if (ring_out_ready) begin
      ring_out_valid <= 1'b0;
    end
  end

  // Eject register toward the local GPU.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      loc_rx_valid <= 1'b0;
      loc_rx_data  <= '0;
    end else if (ej_acc) begin
      loc_rx_valid <= 1'b1;
      loc_rx_data  <= ring_in_data;
    end else if (loc_rx_ready) begin
      loc_rx_valid <= 1'b0;
    end
  end

  // Starvation guard: counts forward wins while injection traffic waits.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      starve_cnt <= '0;
    end else if (!fifo_nonempty || inj_grant) begin
      starve_cnt <= '0;
    end else if (fwd_acc && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Traffic counters, wrapping at 16 bits.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      inj_cnt <= '0;
      fwd_cnt <= '0;
      ej_cnt  <= '0;
    end else begin
      if (inj_grant) inj_cnt <= inj_cnt + 16'd1;
      if (fwd_acc)   fwd_cnt <= fwd_cnt + 16'd1;
      if (ej_acc)    ej_cnt  <= ej_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gpu_ring_stop.sv
// Testbench for gpu_ring_stop: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_gpu_ring_stop;

  localparam int NODE      = 14;
  localparam int DEPTH     = 4;
  localparam int SMAX      = 8;

  logic        ACLK;
  logic        ARESETn;
  logic [15:0] loc_tx_data;
  logic        loc_tx_valid;
  logic        loc_tx_ready;
  logic [15:0] loc_rx_data;
  logic        loc_rx_valid;
  logic        loc_rx_ready;
  logic [15:0] ring_in_data;
  logic        ring_in_valid;
  logic        ring_in_ready;
  logic [15:0] ring_out_data;
  logic        ring_out_valid;
  logic        ring_out_ready;
  logic [2:0]  fifo_level;
  logic [15:0] inj_cnt;
  logic [15:0] fwd_cnt;
  logic [15:0] ej_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  gpu_ring_stop #(.NODE_ID(NODE), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .ACLK           (ACLK),
    .ARESETn        (ARESETn),
    .loc_tx_data    (loc_tx_data),
    .loc_tx_valid   (loc_tx_valid),
    .loc_tx_ready   (loc_tx_ready),
    .loc_rx_data    (loc_rx_data),
    .loc_rx_valid   (loc_rx_valid),
    .loc_rx_ready   (loc_rx_ready),
    .ring_in_data   (ring_in_data),
    .ring_in_valid  (ring_in_valid),
    .ring_in_ready  (ring_in_ready),
    .ring_out_data  (ring_out_data),
    .ring_out_valid (ring_out_valid),
    .ring_out_ready (ring_out_ready),
    .fifo_level     (fifo_level),
    .inj_cnt        (inj_cnt),
    .fwd_cnt        (fwd_cnt),
    .ej_cnt         (ej_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    loc_tx_data    = '0;
    loc_tx_valid   = 1'b0;
    loc_rx_ready   = 1'b0;
    ring_in_data   = '0;
    ring_in_valid  = 1'b0;
    ring_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    idle_inputs();
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // One directed step: inputs for a cycle, expected readies before the edge,
  // expected registered outputs after it.
  typedef struct {
    logic [15:0] rin_d;
    logic        rin_v;
    logic        rout_rdy;
    logic        lrx_rdy;
    logic [15:0] ltx_d;
    logic        ltx_v;
    logic        e_rin_rdy;
    logic        e_tx_rdy;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_rv;
    logic [15:0] e_rd;
    logic [2:0]  e_lvl;
  } vec_t;

  vec_t vecs[9];

  // Reference model state.
  logic [15:0] mq[$];
  logic        m_ov, m_rv;
  logic [15:0] m_od, m_rd;
  int          m_st;
  logic [15:0] m_inj, m_fwd, m_ej;

  initial begin
    logic [9:0]  seq;
    logic        rdy;
    logic        found;
    int          accepts;
    int          stale;
    logic [15:0] got[$];
    logic [15:0] want[5];

    ARESETn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_ring_out_valid", ring_out_valid, 0);
    check("rst_loc_rx_valid",   loc_rx_valid,   0);
    check("rst_ring_out_data",  ring_out_data,  0);
    check("rst_loc_rx_data",    loc_rx_data,    0);
    check("rst_fifo_level",     fifo_level,     0);
    check("rst_loc_tx_ready",   loc_tx_ready,   1);
    check("rst_counters",       {inj_cnt, fwd_cnt | ej_cnt}, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // ---------------- directed vector table ----------------
    //           rin_d     v    ordy lrdy ltx_d     ltxv   rinrdy txrdy ov  od        rv  rd        lvl
    vecs[0] = '{16'h3D23, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3D23, 1'b0, 16'h0000, 3'd0};
    vecs[1] = '{16'h3923, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3923, 3'd0};
    vecs[2] = '{16'h3955, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3923, 3'd0};
    vecs[3] = '{16'h3955, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3923, 3'd0};
    vecs[4] = '{16'h3955, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h3955, 3'd0};
    vecs[5] = '{16'h3955, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0};
    vecs[6] = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h3D23, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd1};
    vecs[7] = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3D23, 1'b0, 16'h0000, 3'd0};
    vecs[8] = '{16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 3'd0};

    for (int i = 0; i < 9; i++) begin
      @(negedge ACLK);
      ring_in_data   = vecs[i].rin_d;
      ring_in_valid  = vecs[i].rin_v;
      ring_out_ready = vecs[i].rout_rdy;
      loc_rx_ready   = vecs[i].lrx_rdy;
      loc_tx_data    = vecs[i].ltx_d;
      loc_tx_valid   = vecs[i].ltx_v;
      #1;
      check($sformatf("vec%0d_ring_in_ready", i), ring_in_ready, vecs[i].e_rin_rdy);
      check($sformatf("vec%0d_loc_tx_ready", i),  loc_tx_ready,  vecs[i].e_tx_rdy);
      @(posedge ACLK);
      #1;
      check($sformatf("vec%0d_ring_out_valid", i), ring_out_valid, vecs[i].e_ov);
      if (vecs[i].e_ov) check($sformatf("vec%0d_ring_out_data", i), ring_out_data, vecs[i].e_od);
      check($sformatf("vec%0d_loc_rx_valid", i), loc_rx_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) check($sformatf("vec%0d_loc_rx_data", i), loc_rx_data, vecs[i].e_rd);
      check($sformatf("vec%0d_fifo_level", i), fifo_level, vecs[i].e_lvl);
    end
    check("table_inj_cnt", inj_cnt, 1);
    check("table_fwd_cnt", fwd_cnt, 1);
    check("table_ej_cnt",  ej_cnt,  2);

    // ---------------- FIFO full, no push-through ----------------
    do_reset();
    @(negedge ACLK);
    ring_in_data  = 16'h3C01;
    ring_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      ring_in_valid = 1'b0;
      loc_tx_valid  = 1'b1;
      loc_tx_data   = 16'h0401 + 16'(i);
      if (i == 4) begin
        #1;
        check("full_fifo_level", fifo_level, 4);
        check("full_loc_tx_ready", loc_tx_ready, 0);
      end
    end
    @(negedge ACLK);
    check("full_level_after_extra_push", fifo_level, 4);
    loc_tx_valid   = 1'b0;
    ring_out_ready = 1'b1;
    want = '{16'h3C01, 16'h0401, 16'h0402, 16'h0403, 16'h0404};
    for (int k = 0; k < 20 && got.size() < 5; k++) begin
      #1;
      if (ring_out_valid) got.push_back(ring_out_data);
      @(negedge ACLK);
    end
    check("full_drain_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      check($sformatf("full_drain_order%0d", i), got[i], want[i]);
    check("full_inj_cnt", inj_cnt, 4);
    check("full_level_empty", fifo_level, 0);

    // ---------------- starvation guard ----------------
    do_reset();
    ring_out_ready = 1'b1;
    loc_rx_ready   = 1'b1;
    seq = '0;
    repeat (3) begin
      @(negedge ACLK);
      ring_in_valid = 1'b1;
      ring_in_data  = {6'd15, seq};
      seq++;
    end
    @(negedge ACLK);
    ring_in_data = {6'd15, seq};
    seq++;
    loc_tx_valid = 1'b1;
    loc_tx_data  = 16'h0777;
    @(posedge ACLK);
    accepts = 0;
    found   = 1'b0;
    rdy     = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge ACLK);
      loc_tx_valid = 1'b0;
      ring_in_data = {6'd15, seq};
      #1 rdy = ring_in_ready;
      @(posedge ACLK);
      #1;
      if (rdy) begin
        accepts++;
        seq++;
      end
      if (ring_out_valid && ring_out_data == 16'h0777) found = 1'b1;
    end
    check("starve_inj_seen", found, 1);
    check("starve_fwd_before_inj", accepts, SMAX);
    check("starve_ring_held_on_inj", rdy, 0);
    @(negedge ACLK);
    ring_in_data = {6'd15, seq};
    #1;
    check("starve_resume_ready", ring_in_ready, 1);
    @(posedge ACLK);
    #1;
    check("starve_resume_valid", ring_out_valid, 1);
    check("starve_resume_data", ring_out_data, {6'd15, seq});
    check("starve_inj_cnt", inj_cnt, 1);
    check("starve_fifo_empty", fifo_level, 0);

    // ---------------- reset mid-traffic ----------------
    do_reset();
    @(negedge ACLK);
    ring_in_valid = 1'b1;
    ring_in_data  = 16'h3C11;
    loc_tx_valid  = 1'b1;
    loc_tx_data   = 16'h0A01;
    @(negedge ACLK);
    ring_in_data  = 16'h3822;
    loc_tx_data   = 16'h0A02;
    @(negedge ACLK);
    ring_in_valid = 1'b0;
    loc_tx_data   = 16'h0A03;
    @(negedge ACLK);
    loc_tx_valid  = 1'b0;
    #1;
    check("mid_pre_level", fifo_level, 3);
    check("mid_pre_out_valid", ring_out_valid, 1);
    check("mid_pre_rx_valid", loc_rx_valid, 1);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_out_valid", ring_out_valid, 0);
    check("mid_rst_rx_valid", loc_rx_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_tx_ready", loc_tx_ready, 1);
    check("mid_rst_counters", {inj_cnt, fwd_cnt | ej_cnt}, 0);
    @(negedge ACLK);
    ARESETn        = 1'b1;
    ring_out_ready = 1'b1;
    loc_rx_ready   = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge ACLK);
      #1;
      if (ring_out_valid || loc_rx_valid || fifo_level != 0) stale++;
    end
    check("mid_no_stale_flit", stale, 0);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    mq.delete();
    m_ov = 1'b0; m_rv = 1'b0; m_od = '0; m_rd = '0; m_st = 0;
    m_inj = '0; m_fwd = '0; m_ej = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0]  dest;
      logic        loc, o_free, e_free, force_i, e_rin_rdy, grant, fwd, ej, push;
      logic [15:0] head;
      @(negedge ACLK);
      dest           = ($urandom_range(0, 1) == 0) ? 6'(NODE) : 6'($urandom_range(0, 63));
      ring_in_valid  = ($urandom_range(0, 3) != 0);
      ring_in_data   = {dest, 10'($urandom)};
      ring_out_ready = ($urandom_range(0, 3) != 0);
      loc_rx_ready   = ($urandom_range(0, 3) != 0);
      loc_tx_valid   = ($urandom_range(0, 1) != 0);
      loc_tx_data    = 16'($urandom);
      #1;
      loc     = (ring_in_data[15:10] == 6'(NODE));
      o_free  = !m_ov || ring_out_ready;
      e_free  = !m_rv || loc_rx_ready;
      force_i = (m_st == SMAX) && (mq.size() != 0);
      e_rin_rdy = loc ? e_free : (o_free && !force_i);
      check("rnd_ring_in_ready", ring_in_ready, e_rin_rdy);
      check("rnd_loc_tx_ready", loc_tx_ready, mq.size() != DEPTH);
      check("rnd_fifo_level", fifo_level, mq.size());
      check("rnd_ring_out_valid", ring_out_valid, m_ov);
      if (m_ov) check("rnd_ring_out_data", ring_out_data, m_od);
      check("rnd_loc_rx_valid", loc_rx_valid, m_rv);
      if (m_rv) check("rnd_loc_rx_data", loc_rx_data, m_rd);
      check("rnd_counters", {inj_cnt, fwd_cnt}, {m_inj, m_fwd});
      check("rnd_ej_cnt", ej_cnt, m_ej);
      // Next state from the behavioural rules.
      grant = o_free && (mq.size() != 0) && (force_i || !(ring_in_valid && !loc));
      fwd   = ring_in_valid && !loc && o_free && !force_i;
      ej    = ring_in_valid && loc && e_free;
      push  = loc_tx_valid && (mq.size() != DEPTH);
      head  = (mq.size() != 0) ? mq[0] : 16'h0;
      if (mq.size() == 0 || grant) m_st = 0;
      else if (fwd && m_st < SMAX) m_st++;
      if (grant) begin void'(mq.pop_front()); m_od = head; m_inj++; end
      if (fwd) begin m_od = ring_in_data; m_fwd++; end
      m_ov = (m_ov && !ring_out_ready) || grant || fwd;
      if (ej) begin m_rd = ring_in_data; m_ej++; end
      m_rv = (m_rv && !loc_rx_ready) || ej;
      if (push) mq.push_back(loc_tx_data);
      @(posedge ACLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
